// File: rtl/frame_fill_raster_pkg.sv
// Shared types and constants for the per-frame clear / rasterizer pixel source.
package frame_fill_raster_pkg;

    typedef logic [11:0]        color12_t;
    typedef logic signed [31:0] q16_16_t;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        q16_16_t     z;
    } vertex_t;

    typedef struct packed {
        vertex_t  v0;
        vertex_t  v1;
        vertex_t  v2;
        color12_t color;
    } triangle_t;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_FILL_WAIT,
        ST_TRIANGLE
    } state_t;

    localparam q16_16_t FILL_DEPTH = 32'h7FFF_FFFF;

endpackage

// File: rtl/frame_fill_raster_fill_scanner.sv
// Raster-order screen clear: walks every pixel once per start, one per handshake.
module fill_scanner
    import frame_fill_raster_pkg::*;
#(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  color12_t    i_color,
    input  logic        i_ready,
    output logic        o_busy,
    output logic        o_valid,
    output logic [15:0] o_x,
    output logic [15:0] o_y,
    output color12_t    o_color
);

    localparam logic [15:0] X_LAST = 16'(WIDTH - 1);
    localparam logic [15:0] Y_LAST = 16'(HEIGHT - 1);

    logic        r_busy;
    logic [15:0] r_x;
    logic [15:0] r_y;
    color12_t    r_color;
    logic        w_last;

    assign w_last = (r_x == X_LAST) && (r_y == Y_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_color <= '0;
        end else if (!r_busy) begin
            // colour is captured here so later loads only affect the next frame
            if (i_start) begin
                r_busy  <= 1'b1;
                r_x     <= '0;
                r_y     <= '0;
                r_color <= i_color;
            end
        end else if (i_ready) begin
            if (w_last) begin
                r_busy <= 1'b0;
            end else if (r_x == X_LAST) begin
                r_x <= '0;
                r_y <= r_y + 16'd1;
            end else begin
                r_x <= r_x + 16'd1;
            end
        end
    end

    assign o_busy  = r_busy;
    assign o_valid = r_busy;
    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_color = r_color;

endmodule

// File: rtl/frame_fill_raster.sv
// Frame sequencer: clear the screen at max depth, then forward the external rasterizer.
module frame_fill_raster
    import frame_fill_raster_pkg::*;
#(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        begin_frame,
    input  triangle_t   triangle,
    input  logic        triangle_valid,
    output logic        triangle_ready,
    input  color12_t    fill_color,
    input  logic        fill_valid,
    output logic        fill_ready,
    output logic [15:0] out_pixel_x,
    output logic [15:0] out_pixel_y,
    output q16_16_t     out_depth,
    output color12_t    out_color,
    output logic        out_compare_depth,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output triangle_t   ras_triangle,
    output logic        ras_in_valid,
    input  logic        ras_in_ready,
    input  logic        ras_busy,
    input  logic [15:0] ras_x,
    input  logic [15:0] ras_y,
    input  q16_16_t     ras_depth,
    input  color12_t    ras_color,
    input  logic        ras_out_valid,
    output logic        ras_out_ready
);

    state_t      r_state;
    state_t      w_next;
    color12_t    r_fill_color;
    logic        w_fill_start;
    logic        w_fill_busy;
    logic        w_fill_valid;
    logic        w_fill_ready;
    logic [15:0] w_fill_x;
    logic [15:0] w_fill_y;
    color12_t    w_fill_color;
    logic        w_in_tri;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_fill_color <= '0;
        else if (fill_valid) r_fill_color <= fill_color;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_FILL;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_fill_start = 1'b0;
        case (r_state)
            ST_FILL: begin
                w_fill_start = 1'b1;
                w_next       = ST_FILL_WAIT;
            end
            ST_FILL_WAIT: if (!w_fill_busy && triangle_valid) w_next = ST_TRIANGLE;
            ST_TRIANGLE:  if (begin_frame) w_next = ST_FILL;
            default:      w_next = ST_FILL;
        endcase
    end

    assign w_in_tri     = (r_state == ST_TRIANGLE);
    assign w_fill_ready = out_ready && !w_in_tri;

    fill_scanner #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_fill (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_fill_start),
        .i_color (r_fill_color),
        .i_ready (w_fill_ready),
        .o_busy  (w_fill_busy),
        .o_valid (w_fill_valid),
        .o_x     (w_fill_x),
        .o_y     (w_fill_y),
        .o_color (w_fill_color)
    );

    always_comb begin
        out_pixel_x       = w_fill_x;
        out_pixel_y       = w_fill_y;
        out_depth         = FILL_DEPTH;
        out_color         = w_fill_color;
        out_compare_depth = 1'b0;
        out_valid         = w_fill_valid;
        busy              = w_fill_busy;
        if (w_in_tri) begin
            out_pixel_x       = ras_x;
            out_pixel_y       = ras_y;
            out_depth         = ras_depth;
            out_color         = ras_color;
            out_compare_depth = 1'b1;
            out_valid         = ras_out_valid;
            busy              = ras_busy;
        end
    end

    // rasterizer output is stalled, not dropped, while a fill owns the pixel port
    assign ras_out_ready  = out_ready && w_in_tri;
    assign ras_in_valid   = triangle_valid && w_in_tri;
    assign triangle_ready = ras_in_ready && w_in_tri;
    assign ras_triangle   = triangle;
    assign fill_ready     = 1'b1;

endmodule

// File: tb/tb_frame_fill_raster.sv
// Self-checking bench for frame_fill_raster on a 4x2 screen.
module tb_frame_fill_raster;
    import frame_fill_raster_pkg::*;

    localparam int W = 4;
    localparam int H = 2;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        begin_frame = 1'b0;
    triangle_t   triangle = '0;
    logic        triangle_valid = 1'b0;
    logic        triangle_ready;
    color12_t    fill_color = '0;
    logic        fill_valid = 1'b0;
    logic        fill_ready;
    logic [15:0] out_pixel_x, out_pixel_y;
    q16_16_t     out_depth;
    color12_t    out_color;
    logic        out_compare_depth, out_valid;
    logic        out_ready = 1'b1;
    logic        busy;
    triangle_t   ras_triangle;
    logic        ras_in_valid;
    logic        ras_in_ready = 1'b0;
    logic        ras_busy = 1'b0;
    logic [15:0] ras_x = '0, ras_y = '0;
    q16_16_t     ras_depth = '0;
    color12_t    ras_color = '0;
    logic        ras_out_valid = 1'b0;
    logic        ras_out_ready;

    always #5 clk = ~clk;

    frame_fill_raster #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .begin_frame(begin_frame),
        .triangle(triangle), .triangle_valid(triangle_valid), .triangle_ready(triangle_ready),
        .fill_color(fill_color), .fill_valid(fill_valid), .fill_ready(fill_ready),
        .out_pixel_x(out_pixel_x), .out_pixel_y(out_pixel_y), .out_depth(out_depth),
        .out_color(out_color), .out_compare_depth(out_compare_depth),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .ras_triangle(ras_triangle), .ras_in_valid(ras_in_valid), .ras_in_ready(ras_in_ready),
        .ras_busy(ras_busy), .ras_x(ras_x), .ras_y(ras_y), .ras_depth(ras_depth),
        .ras_color(ras_color), .ras_out_valid(ras_out_valid), .ras_out_ready(ras_out_ready)
    );

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [11:0] c;
        logic [31:0] d;
        logic        cmp;
    } pix_t;

    pix_t got[$];
    pix_t exp_q[$];
    bit   saw_ras_rdy, saw_tri_rdy, saw_ras_in_v;
    int   total = 0;
    int   bad = 0;

    // Reference: a clear visits every screen position once, row by row.
    function automatic void model_fill(input logic [11:0] col);
        pix_t p;
        exp_q.delete();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                p.x = 16'(x); p.y = 16'(y); p.c = col; p.d = 32'h7FFF_FFFF; p.cmp = 1'b0;
                exp_q.push_back(p);
            end
    endfunction

    function automatic pix_t cur_pix();
        pix_t p;
        p.x = out_pixel_x; p.y = out_pixel_y; p.c = out_color;
        p.d = out_depth; p.cmp = out_compare_depth;
        return p;
    endfunction

    function automatic triangle_t rand_tri();
        triangle_t t;
        t.v0.x = 16'($urandom); t.v0.y = 16'($urandom); t.v0.z = $urandom;
        t.v1.x = 16'($urandom); t.v1.y = 16'($urandom); t.v1.z = $urandom;
        t.v2.x = 16'($urandom); t.v2.y = 16'($urandom); t.v2.z = $urandom;
        t.color = 12'($urandom);
        return t;
    endfunction

    // Stimulus only: accept pixels with out_ready=1, optionally loading a colour mid-fill.
    task automatic collect(input int target, input int budget, input int inj_at,
                           input logic [11:0] inj_col, output int cycles);
        got.delete();
        saw_ras_rdy = 0; saw_tri_rdy = 0; saw_ras_in_v = 0;
        cycles = 0;
        while (got.size() < target && cycles < budget) begin
            @(negedge clk);
            out_ready  = 1'b1;
            fill_valid = (got.size() == inj_at);
            fill_color = inj_col;
            #1;
            cycles++;
            if (ras_out_ready)  saw_ras_rdy = 1;
            if (triangle_ready) saw_tri_rdy = 1;
            if (ras_in_valid)   saw_ras_in_v = 1;
            if (out_valid) got.push_back(cur_pix());
        end
        @(negedge clk);
        fill_valid = 1'b0;
        #1;
    endtask

    // Stimulus only: from an idle FILL_WAIT, enter TRIANGLE and request a new frame.
    // Returns inside the FILL cycle.
    task automatic start_frame();
        triangle_valid = 1'b1;
        @(negedge clk);
        triangle_valid = 1'b0;
        begin_frame = 1'b1;
        @(negedge clk);
        begin_frame = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_out: valid=%b busy=%b want 0 0", out_valid, busy);
        end
        total++;
        if (fill_ready !== 1'b1 || triangle_ready !== 1'b0) begin
            bad++; $display("FAIL reset_rdy: fill_ready=%b tri_ready=%b want 1 0", fill_ready, triangle_ready);
        end
        triangle_valid = 1'b1;
        ras_in_ready   = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL fill_cycle: valid=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_first_fill();
        int cyc;
        model_fill(12'h000);
        collect(NPIX, 40, -1, 12'h000, cyc);
        total++;
        if (got.size() !== NPIX || cyc !== NPIX) begin
            bad++; $display("FAIL first_count: pixels=%0d cycles=%0d want %0d %0d", got.size(), cyc, NPIX, NPIX);
        end
        for (int i = 0; i < got.size() && i < NPIX; i++) begin
            total++;
            if (got[i] !== exp_q[i]) begin
                bad++; $display("FAIL first_pix%0d: got %h want %h", i, got[i], exp_q[i]);
            end
        end
        total++;
        if (saw_tri_rdy || saw_ras_in_v || saw_ras_rdy) begin
            bad++; $display("FAIL fill_gate: tri_rdy=%b ras_in_v=%b ras_out_rdy=%b want 0 0 0",
                            saw_tri_rdy, saw_ras_in_v, saw_ras_rdy);
        end
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || triangle_ready !== 1'b0) begin
            bad++; $display("FAIL fill_end: busy=%b valid=%b tri_rdy=%b want 0 0 0", busy, out_valid, triangle_ready);
        end
    endtask

    task automatic test_triangle();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            triangle       = rand_tri();
            triangle_valid = 1'($urandom);
            ras_in_ready   = 1'($urandom);
            ras_busy       = 1'($urandom);
            ras_x = 16'($urandom); ras_y = 16'($urandom);
            ras_depth = $urandom; ras_color = 12'($urandom);
            ras_out_valid  = 1'($urandom);
            out_ready      = 1'($urandom);
            #1;
            total++;
            if (triangle_ready !== ras_in_ready || ras_in_valid !== triangle_valid || ras_triangle !== triangle) begin
                bad++; $display("FAIL tri_in%0d: rdy=%b v=%b want %b %b", i, triangle_ready, ras_in_valid,
                                ras_in_ready, triangle_valid);
            end
            total++;
            if (out_pixel_x !== ras_x || out_pixel_y !== ras_y || out_depth !== ras_depth ||
                out_color !== ras_color || out_valid !== ras_out_valid || out_compare_depth !== 1'b1) begin
                bad++; $display("FAIL tri_out%0d: got %h,%h,%h,%h v=%b c=%b want %h,%h,%h,%h v=%b c=1", i,
                                out_pixel_x, out_pixel_y, out_depth, out_color, out_valid, out_compare_depth,
                                ras_x, ras_y, ras_depth, ras_color, ras_out_valid);
            end
            total++;
            if (busy !== ras_busy || ras_out_ready !== out_ready) begin
                bad++; $display("FAIL tri_ctl%0d: busy=%b ras_out_rdy=%b want %b %b", i, busy, ras_out_ready,
                                ras_busy, out_ready);
            end
        end
        @(negedge clk);
        fill_color = 12'hABC; fill_valid = 1'b1;
        ras_busy = 1'b0; triangle_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        fill_valid = 1'b0;
    endtask

    task automatic test_fill_color();
        int cyc;
        ras_out_valid = 1'b1;
        start_frame();
        total++;
        if (out_valid !== 1'b0 || ras_out_ready !== 1'b0 || out_compare_depth !== 1'b0) begin
            bad++; $display("FAIL refill_cycle: valid=%b ras_out_rdy=%b cmp=%b want 0 0 0",
                            out_valid, ras_out_ready, out_compare_depth);
        end
        model_fill(12'hABC);
        collect(NPIX, 40, 3, 12'h123, cyc);
        total++;
        if (got.size() !== NPIX || cyc !== NPIX) begin
            bad++; $display("FAIL color_count: pixels=%0d cycles=%0d want %0d %0d", got.size(), cyc, NPIX, NPIX);
        end
        for (int i = 0; i < got.size() && i < NPIX; i++) begin
            total++;
            if (got[i] !== exp_q[i]) begin
                bad++; $display("FAIL color_pix%0d: got %h want %h", i, got[i], exp_q[i]);
            end
        end
        total++;
        if (saw_ras_rdy) begin
            bad++; $display("FAIL refill_ras_rdy: got 1 want 0");
        end
        ras_out_valid = 1'b0;
    endtask

    task automatic test_stall();
        bit    pat[3] = '{1'b1, 1'b0, 1'b1};
        bit    prev_stall = 0;
        pix_t  held;
        int    cyc = 0;
        int    holds = 0;
        start_frame();
        model_fill(12'h123);
        got.delete();
        while (got.size() < NPIX && cyc < 80) begin
            @(negedge clk);
            out_ready = (cyc < 3) ? pat[cyc] : 1'($urandom_range(0, 1));
            #1;
            cyc++;
            if (prev_stall) begin
                holds++;
                total++;
                if (out_valid !== 1'b1 || cur_pix() !== held) begin
                    bad++; $display("FAIL stall_hold: got v=%b %h want v=1 %h", out_valid, cur_pix(), held);
                end
            end
            if (out_valid && out_ready) got.push_back(cur_pix());
            prev_stall = out_valid && !out_ready;
            held = cur_pix();
        end
        total++;
        if (got.size() !== NPIX || holds == 0) begin
            bad++; $display("FAIL stall_count: handshakes=%0d holds=%0d want %0d >0", got.size(), holds, NPIX);
        end
        for (int i = 0; i < got.size() && i < NPIX; i++) begin
            total++;
            if (got[i] !== exp_q[i]) begin
                bad++; $display("FAIL stall_pix%0d: got %h want %h", i, got[i], exp_q[i]);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL stall_end: busy=%b valid=%b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_reset_midfill();
        int cyc;
        start_frame();
        collect(3, 20, -1, 12'h000, cyc);
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL midreset: valid=%b busy=%b want 0 0", out_valid, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        model_fill(12'h000);
        collect(NPIX, 40, -1, 12'h000, cyc);
        total++;
        if (got.size() !== NPIX || cyc !== NPIX) begin
            bad++; $display("FAIL restart_count: pixels=%0d cycles=%0d want %0d %0d", got.size(), cyc, NPIX, NPIX);
        end
        for (int i = 0; i < got.size() && i < NPIX; i++) begin
            total++;
            if (got[i] !== exp_q[i]) begin
                bad++; $display("FAIL restart_pix%0d: got %h want %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_fill();
        test_triangle();
        test_fill_color();
        test_stall();
        test_reset_midfill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
